// File: rtl/bp_cfg_arbiter.sv
// bp_cfg_arbiter: two-requester round-robin front end for a single cfg block.
// Commands are granted round-robin. The granted requester's id is recorded in a
// small tag FIFO, so in-order responses go back to whoever asked. A response
// that arrives with no tag outstanding is drained and flagged on err_o.
module bp_cfg_arbiter #(
  parameter int msg_width_p = 256,
  parameter int tag_els_p   = 4,
  localparam int ptr_w_lp   = $clog2(tag_els_p),
  localparam int cnt_w_lp   = ptr_w_lp + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [2*msg_width_p-1:0] req_cmd_i,
  input  logic [1:0]               req_cmd_v_i,
  output logic [1:0]               req_cmd_ready_o,
  output logic [msg_width_p-1:0]   req_resp_o,
  output logic [1:0]               req_resp_v_o,
  input  logic [1:0]               req_resp_yumi_i,
  output logic [msg_width_p-1:0]   mem_cmd_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]   mem_resp_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  output logic [cnt_w_lp-1:0]      outstanding_o,
  output logic                     err_o
);

  logic                prio_q, prio_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                tags_q [tag_els_p];

  logic grant, head, full, empty, any_v, push, pop, orphan;

  // Arbitration, response routing and next-state computation. Every handshake
  // output is also qualified by reset_n_i, so it drops as soon as reset asserts.
  always_comb begin
    any_v = |req_cmd_v_i;
    grant = prio_q;
    if (!req_cmd_v_i[prio_q]) grant = ~prio_q;
    full  = (cnt_q == cnt_w_lp'(tag_els_p));
    empty = (cnt_q == '0);
    head  = tags_q[rd_ptr_q];

    mem_cmd_o   = grant ? req_cmd_i[2*msg_width_p-1:msg_width_p]
                        : req_cmd_i[msg_width_p-1:0];
    mem_cmd_v_o = reset_n_i & any_v & ~full;

    req_cmd_ready_o = '0;
    if (reset_n_i && any_v && mem_cmd_ready_i && !full) req_cmd_ready_o[grant] = 1'b1;
    push = mem_cmd_v_o & mem_cmd_ready_i;

    req_resp_o   = mem_resp_i;
    req_resp_v_o = '0;
    if (reset_n_i && mem_resp_v_i && !empty) req_resp_v_o[head] = 1'b1;
    pop    = req_resp_v_o[head] & req_resp_yumi_i[head];
    orphan = reset_n_i & mem_resp_v_i & empty;
    mem_resp_yumi_o = pop | orphan;

    // A full FIFO never pushes, so a same-cycle pop cannot make room for it.
    prio_d   = push ? ~grant : prio_q;
    wr_ptr_d = wr_ptr_q + ptr_w_lp'(push);
    rd_ptr_d = rd_ptr_q + ptr_w_lp'(pop);
    cnt_d    = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    err_d    = err_q | orphan;

    outstanding_o = cnt_q;
    err_o         = err_q;
  end

  // State registers. Reset drops every outstanding tag, so responses that
  // arrive after reset are treated as orphans.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < tag_els_p; i++) tags_q[i] <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) tags_q[wr_ptr_q] <= grant;
    end
  end

endmodule

// File: tb/tb_bp_cfg_arbiter.sv
// Directed bench for bp_cfg_arbiter (8-bit messages, 4 tags).
module tb_bp_cfg_arbiter;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b1;
  logic [2*W-1:0] req_cmd_i;
  logic [1:0]     req_cmd_v_i = '0;
  logic [1:0]     req_cmd_ready_o;
  logic [W-1:0]   req_resp_o;
  logic [1:0]     req_resp_v_o;
  logic [1:0]     req_resp_yumi_i = '0;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i = 1'b0;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i = 1'b0;
  logic           mem_resp_yumi_o;
  logic [2:0]     outstanding_o;
  logic           err_o;

  int passed = 0;
  int total  = 0;

  bp_cfg_arbiter #(.msg_width_p(W), .tag_els_p(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_cmd_i(req_cmd_i), .req_cmd_v_i(req_cmd_v_i), .req_cmd_ready_o(req_cmd_ready_o),
    .req_resp_o(req_resp_o), .req_resp_v_o(req_resp_v_o), .req_resp_yumi_i(req_resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // drive inputs, then let combinational outputs settle
  task automatic drv(input logic [1:0] v, input logic rdy, input logic rv, input logic [1:0] y);
    req_cmd_v_i = v; mem_cmd_ready_i = rdy; mem_resp_v_i = rv; req_resp_yumi_i = y;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    req_cmd_i  = {8'hB1, 8'hA0};
    mem_resp_i = 8'h5C;
    #1 reset_n_i = 1'b0;
    drv(2'b11, 1'b1, 1'b1, 2'b11);
    #10;
    chk("rst_cmd_v", 32'(mem_cmd_v_o), 0);
    chk("rst_ready", 32'(req_cmd_ready_o), 0);
    chk("rst_resp_v", 32'(req_resp_v_o), 0);
    chk("rst_yumi", 32'(mem_resp_yumi_o), 0);
    chk("rst_outst", 32'(outstanding_o), 0);
    chk("rst_err", 32'(err_o), 0);
    drv(2'b00, 1'b0, 1'b0, 2'b00);
    reset_n_i = 1'b1;
    tick();

    // alternating grants, responses one cycle later
    for (int i = 0; i < 4; i++) begin
      drv(2'b11, 1'b1, i > 0, 2'b11);
      chk("alt_cmd", 32'(mem_cmd_o), (i % 2 == 0) ? 32'hA0 : 32'hB1);
      chk("alt_ready", 32'(req_cmd_ready_o), (i % 2 == 0) ? 1 : 2);
      chk("alt_resp_v", 32'(req_resp_v_o), (i == 0) ? 0 : ((i % 2 == 1) ? 1 : 2));
      tick();
      chk("alt_outst", 32'(outstanding_o), 1);
    end
    drv(2'b01, 1'b1, 1'b1, 2'b11);
    chk("c4_resp_v", 32'(req_resp_v_o), 2);
    chk("c4_cmd", 32'(mem_cmd_o), 32'hA0);
    chk("c4_resp_data", 32'(req_resp_o), 32'h5C);
    tick();
    chk("c4_outst", 32'(outstanding_o), 1);

    // stall with requester 1 favoured; grant must not switch mid-handshake
    for (int i = 0; i < 5; i++) begin
      drv(2'b10, 1'b0, 1'b0, 2'b00);
      chk("stall_cmd", 32'(mem_cmd_o), 32'hB1);
      chk("stall_v", 32'(mem_cmd_v_o), 1);
      chk("stall_ready", 32'(req_cmd_ready_o), 0);
      tick();
    end
    drv(2'b11, 1'b0, 1'b0, 2'b00);
    chk("hold_cmd", 32'(mem_cmd_o), 32'hB1);
    tick();
    drv(2'b11, 1'b1, 1'b0, 2'b00);
    chk("xfer1_ready", 32'(req_cmd_ready_o), 2);
    chk("xfer1_cmd", 32'(mem_cmd_o), 32'hB1);
    tick();
    drv(2'b11, 1'b1, 1'b0, 2'b00);
    chk("xfer0_ready", 32'(req_cmd_ready_o), 1);
    chk("xfer0_cmd", 32'(mem_cmd_o), 32'hA0);
    tick();
    chk("xfer_outst", 32'(outstanding_o), 3);

    // in-order drain 0,1,0; wrong-bit yumi is ignored
    drv(2'b00, 1'b0, 1'b1, 2'b10);
    chk("ign_resp_v", 32'(req_resp_v_o), 1);
    chk("ign_yumi", 32'(mem_resp_yumi_o), 0);
    tick();
    chk("ign_outst", 32'(outstanding_o), 3);
    drv(2'b00, 1'b0, 1'b1, 2'b01);
    chk("dr0_yumi", 32'(mem_resp_yumi_o), 1);
    tick();
    drv(2'b00, 1'b0, 1'b1, 2'b10);
    chk("dr1_resp_v", 32'(req_resp_v_o), 2);
    tick();
    drv(2'b00, 1'b0, 1'b1, 2'b01);
    chk("dr2_resp_v", 32'(req_resp_v_o), 1);
    tick();
    chk("dr_outst", 32'(outstanding_o), 0);

    // fill the tag FIFO from requester 0
    for (int i = 0; i < 4; i++) begin
      drv(2'b01, 1'b1, 1'b0, 2'b00);
      chk("fill_ready", 32'(req_cmd_ready_o), 1);
      tick();
    end
    chk("full_outst", 32'(outstanding_o), 4);
    drv(2'b01, 1'b1, 1'b0, 2'b00);
    chk("full_cmd_v", 32'(mem_cmd_v_o), 0);
    chk("full_ready", 32'(req_cmd_ready_o), 0);
    drv(2'b01, 1'b1, 1'b1, 2'b01);
    chk("full_pop_yumi", 32'(mem_resp_yumi_o), 1);
    chk("full_pop_cmd_v", 32'(mem_cmd_v_o), 0);
    tick();
    chk("pop_outst", 32'(outstanding_o), 3);
    drv(2'b01, 1'b1, 1'b0, 2'b00);
    chk("fifth_ready", 32'(req_cmd_ready_o), 1);
    tick();
    chk("fifth_outst", 32'(outstanding_o), 4);
    for (int i = 0; i < 4; i++) begin
      drv(2'b00, 1'b0, 1'b1, 2'b01);
      chk("drain_resp_v", 32'(req_resp_v_o), 1);
      tick();
    end
    chk("drain_outst", 32'(outstanding_o), 0);

    // simultaneous push and pop at occupancy 2, after pointer wrap
    drv(2'b11, 1'b1, 1'b0, 2'b00);
    chk("sp_cmd1", 32'(mem_cmd_o), 32'hB1);
    tick();
    drv(2'b11, 1'b1, 1'b0, 2'b00);
    chk("sp_cmd0", 32'(mem_cmd_o), 32'hA0);
    tick();
    drv(2'b11, 1'b1, 1'b1, 2'b11);
    chk("sp_cmd", 32'(mem_cmd_o), 32'hB1);
    chk("sp_resp_v", 32'(req_resp_v_o), 2);
    chk("sp_yumi", 32'(mem_resp_yumi_o), 1);
    tick();
    chk("sp_outst", 32'(outstanding_o), 2);
    drv(2'b00, 1'b0, 1'b1, 2'b11);
    chk("sp_dr0", 32'(req_resp_v_o), 1);
    tick();
    drv(2'b00, 1'b0, 1'b1, 2'b11);
    chk("sp_dr1", 32'(req_resp_v_o), 2);
    tick();
    chk("sp_outst0", 32'(outstanding_o), 0);

    // orphan response
    drv(2'b00, 1'b0, 1'b1, 2'b00);
    chk("orph_yumi", 32'(mem_resp_yumi_o), 1);
    chk("orph_resp_v", 32'(req_resp_v_o), 0);
    chk("orph_err_pre", 32'(err_o), 0);
    tick();
    chk("orph_err", 32'(err_o), 1);
    drv(2'b00, 1'b0, 1'b0, 2'b00);
    tick();
    chk("orph_err_sticky", 32'(err_o), 1);
    chk("orph_outst", 32'(outstanding_o), 0);

    // async reset with 3 outstanding and priority on requester 1
    for (int i = 0; i < 3; i++) begin
      drv(2'b01, 1'b1, 1'b0, 2'b00);
      tick();
    end
    chk("pre_rst_outst", 32'(outstanding_o), 3);
    drv(2'b11, 1'b1, 1'b1, 2'b11);
    chk("pre_rst_cmd", 32'(mem_cmd_o), 32'hB1);
    reset_n_i = 1'b0;
    #1;
    chk("arst_outst", 32'(outstanding_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_cmd_v", 32'(mem_cmd_v_o), 0);
    chk("arst_ready", 32'(req_cmd_ready_o), 0);
    chk("arst_resp_v", 32'(req_resp_v_o), 0);
    chk("arst_yumi", 32'(mem_resp_yumi_o), 0);
    tick();
    reset_n_i = 1'b1;
    drv(2'b00, 1'b0, 1'b1, 2'b00);
    chk("post_orph_yumi", 32'(mem_resp_yumi_o), 1);
    chk("post_orph_resp_v", 32'(req_resp_v_o), 0);
    tick();
    chk("post_err", 32'(err_o), 1);
    chk("post_outst", 32'(outstanding_o), 0);
    drv(2'b11, 1'b1, 1'b0, 2'b00);
    chk("post_cmd", 32'(mem_cmd_o), 32'hA0);
    chk("post_ready", 32'(req_cmd_ready_o), 1);
    tick();
    chk("post_outst1", 32'(outstanding_o), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bp_cfg_arbiter.md
BP_CFG_ARBITER -- requirements
Module: bp_cfg_arbiter

Interface
REQ-001 SHALL have parameter msg_width_p, default 256: width of one memory command/response message, carried opaque.
REQ-002 SHALL have parameter tag_els_p, default 4: maximum outstanding commands; power of two, >=2.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports req_cmd_i  input  2*msg_width_p  command from requester r at bits [r*msg_width_p +: msg_width_p], r in {0,1}.
REQ-006 SHALL have ports req_cmd_v_i  input  2  and  req_cmd_ready_o  output  2: per-requester valid/ready command handshake.
REQ-007 SHALL have ports req_resp_o  output  msg_width_p,  req_resp_v_o  output  2,  req_resp_yumi_i  input  2: response to requester r.
REQ-008 SHALL have ports mem_cmd_o  output  msg_width_p,  mem_cmd_v_o  output  1,  mem_cmd_ready_i  input  1: command toward the cfg block.
REQ-009 SHALL have ports mem_resp_i  input  msg_width_p,  mem_resp_v_i  input  1,  mem_resp_yumi_o  output  1: response from the cfg block.
REQ-010 SHALL have ports outstanding_o  output  $clog2(tag_els_p)+1  (tag FIFO occupancy) and err_o  output  1  (sticky orphan-response flag).

Function
REQ-011 SHALL arbitrate the two requesters round-robin; priority pointer p (1 bit) names the favoured requester.
REQ-012 SHALL choose grant g = p if req_cmd_v_i[p], else ~p if req_cmd_v_i[~p]; no grant if neither valid.
REQ-013 SHALL drive mem_cmd_v_o = (any req_cmd_v_i) & ~tag_full, combinationally, zero-cycle latency.
REQ-014 SHALL drive mem_cmd_o = req_cmd_i slice of g; value don't-care when mem_cmd_v_o=0.
REQ-015 SHALL assert req_cmd_ready_o[g] = mem_cmd_ready_i & ~tag_full; req_cmd_ready_o[~g] SHALL be 0.
REQ-016 SHALL define a command transfer as mem_cmd_v_o & mem_cmd_ready_i; on transfer, SHALL push g into the tag FIFO and set p <= ~g.
REQ-017 SHALL leave p unchanged on cycles with no transfer (grant holds while downstream stalls; no switching mid-handshake).
REQ-018 SHALL implement the tag FIFO as a tag_els_p-entry circular buffer, read/write pointers wrapping modulo tag_els_p, with an occupancy counter.
REQ-019 SHALL assert tag_full when occupancy == tag_els_p; commands then SHALL be blocked (ready/valid low) until a response pops.
REQ-020 SHALL route responses in order: head tag h selects the destination; req_resp_v_o[h] = mem_resp_v_i & ~tag_empty, req_resp_v_o[~h] = 0.
REQ-021 SHALL drive req_resp_o = mem_resp_i combinationally.
REQ-022 SHALL drive mem_resp_yumi_o = req_resp_yumi_i[h] & req_resp_v_o[h]; on it, SHALL pop the tag FIFO.
REQ-023 SHALL, on simultaneous push and pop, keep occupancy unchanged and advance both pointers; push SHALL be permitted when full only if... never: full blocks push even with same-cycle pop.
REQ-024 SHALL, when mem_resp_v_i=1 and tag FIFO empty, assert mem_resp_yumi_o=1 (drain the orphan), deliver to no requester, and set err_o<=1.
REQ-025 SHALL keep err_o set until reset.
REQ-026 SHALL ignore req_resp_yumi_i bits not matching h, and yumi while req_resp_v_o low.

Reset
REQ-027 SHALL, while reset_n_i=0, asynchronously clear p to 0, both pointers and occupancy to 0, err_o to 0.
REQ-028 SHALL, during reset, hold mem_cmd_v_o=0, req_cmd_ready_o=0, req_resp_v_o=0, mem_resp_yumi_o=0, outstanding_o=0.
REQ-029 SHALL, on reset assertion mid-handshake, discard all outstanding tags; post-reset responses are orphans per REQ-024.
REQ-030 SHALL resume arbitration on the first rising clk_i after reset_n_i deasserts.

Verification
REQ-031 Both requesters valid every cycle, mem_cmd_ready_i=1, responses returned 1 cycle later -> grants alternate 0,1,0,1; responses routed 0,1,0,1; outstanding_o never >2.
REQ-032 mem_cmd_ready_i=0 for 5 cycles with only requester 1 valid, then requester 0 also valid -> grant stays 1 until transfer; next transfer goes to 0.
REQ-033 Requester 0 issues 4 commands, no responses (tag_els_p=4) -> outstanding_o=4, mem_cmd_v_o=0, both ready 0; one response yumi'd -> outstanding_o=3, fifth command accepted next cycle.
REQ-034 Push and pop in same cycle at occupancy 2 -> occupancy stays 2; pointer wrap after 9 transfers keeps in-order routing correct.
REQ-035 mem_resp_v_i=1 with empty FIFO -> mem_resp_yumi_o=1 that cycle, req_resp_v_o=00, err_o=1 next edge and stays 1.
REQ-036 reset_n_i pulsed low with 3 outstanding -> outputs clear immediately (asynchronous); outstanding_o=0, p=0 after release.
